// File: rtl/inst_memory_pkg.sv
// Shared constants and types for the instruction memory block.
// No logic here; imported by the interface users, top and bench.
// Address map, burst-size encodings and FSM state type live here.
package inst_memory_pkg;

    // Byte address of word 0; fetch uses the same base.
    localparam logic [31:0] INST_BASE_ADDR   = 32'h8002_0000;
    localparam int          INST_DEPTH_WORDS = 16384;
    localparam int          INST_ADDR_W      = 14;
    localparam int          WORD_BYTES       = 4;

    typedef enum logic [1:0] {
        ACCESS_1W  = 2'b00,
        ACCESS_4W  = 2'b01,
        ACCESS_8W  = 2'b10,
        ACCESS_16W = 2'b11
    } access_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Number of beats encoded by an access_size field.
    function automatic logic [4:0] beats_of(input logic [1:0] size);
        logic [4:0] n;
        case (access_e'(size))
            ACCESS_1W:  n = 5'd1;
            ACCESS_4W:  n = 5'd4;
            ACCESS_8W:  n = 5'd8;
            default:    n = 5'd16;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/inst_memory_if.sv
// Fetch-side request/response bundle for the instruction memory.
// Carries no state; timing is defined by the memory behind the slave modport.
// No handshake back to the requester beyond busy; requests while busy are dropped.
interface inst_memory_if;
    logic        enable;
    logic [31:0] address;
    logic [1:0]  access_size;
    logic        rw;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        valid;
    logic        busy;
    logic        addr_err;

    modport master (
        output enable, address, access_size, rw, data_in,
        input  data_out, valid, busy, addr_err
    );

    modport slave (
        input  enable, address, access_size, rw, data_in,
        output data_out, valid, busy, addr_err
    );
endinterface

// File: rtl/inst_memory_sram_sp.sv
// Single-port synchronous word array with registered read data.
// Latency: rdata reflects addr one cycle after the edge that sampled it.
// No backpressure; one access (read or write) per cycle.
module sram_sp #(
    parameter int DEPTH = 16384,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Array write and registered read; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/inst_memory.sv
// Instruction memory: single-word and burst reads/writes with start-only range check.
// Latency: a beat executed on edge N shows data_out/valid in the cycle after edge N.
// Backpressure: busy during bursts; any request seen while busy is silently ignored.
module inst_memory
    import inst_memory_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = INST_BASE_ADDR,
    parameter int          DEPTH_WORDS = INST_DEPTH_WORDS,
    parameter int          ADDR_W      = INST_ADDR_W
) (
    input  logic          clock,
    input  logic          reset_n,
    inst_memory_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [3:0]        rem_q, rem_d;
    logic              rw_q, rw_d;
    logic              valid_q, err_q;

    logic [29:0]       off_words;
    logic              in_range;
    logic [ADDR_W-1:0] start_idx;
    logic [4:0]        beats;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              rd_beat;
    logic              reject;
    logic              unused_lsbs;

    // Byte offset bits are irrelevant: every access is a whole word.
    assign unused_lsbs = ^bus.address[1:0];

    // Word offset from the base; a below-base address is caught separately
    // because the subtraction would wrap into an apparently valid index.
    assign off_words = bus.address[31:2] - BASE_ADDR[31:2];
    assign in_range  = (bus.address >= BASE_ADDR) && (off_words < 30'(DEPTH_WORDS));
    assign start_idx = off_words[ADDR_W-1:0];
    assign beats     = beats_of(bus.access_size);

    // Beat sequencing: beat 0 runs on the accepting edge, the rest from BURST.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        rw_d     = rw_q;
        mem_we   = 1'b0;
        mem_addr = idx_q;
        rd_beat  = 1'b0;
        reject   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    if (!in_range) begin
                        reject = 1'b1;
                    end else begin
                        mem_addr = start_idx;
                        mem_we   = !bus.rw;
                        rd_beat  = bus.rw;
                        if (beats != 5'd1) begin
                            state_d = ST_BURST;
                            idx_d   = start_idx + ADDR_W'(1);
                            rem_d   = 4'(beats - 5'd1);
                            rw_d    = bus.rw;
                        end
                    end
                end
            end
            ST_BURST: begin
                mem_addr = idx_q;
                mem_we   = !rw_q;
                rd_beat  = rw_q;
                // Index wraps naturally at the array size.
                idx_d    = idx_q + ADDR_W'(1);
                rem_d    = rem_q - 4'd1;
                if (rem_q == 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, burst bookkeeping and response flags; reset aborts any burst.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            rw_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            rw_q    <= rw_d;
            valid_q <= rd_beat;
            err_q   <= reject;
        end
    end

    sram_sp #(
        .DEPTH (DEPTH_WORDS),
        .AW    (ADDR_W)
    ) u_sram (
        .clk   (clock),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (bus.data_in),
        .rdata (mem_rdata)
    );

    // The array read register has no reset, so it is masked to zero
    // whenever the cycle carries no read beat (reset, reject, idle, write).
    assign bus.data_out = valid_q ? mem_rdata : 32'h0;
    assign bus.valid    = valid_q;
    assign bus.busy     = (state_q == ST_BURST);
    assign bus.addr_err = err_q;

endmodule
